// File: rtl/icache_refill_ctrl_pkg.sv
// Shared ICache definitions: refill state encoding, line geometry, AXI burst constants
// and one-hot helpers used by the refill sequencer.
package icache_refill_ctrl_pkg;

  localparam int OFFSET    = 5;
  localparam int INDEX     = 7;
  localparam int TAG       = 20;
  localparam int BEATS     = 8;
  localparam int INDEXWIDE = INDEX;
  localparam int TAGWIDE   = TAG;

  localparam logic [7:0] AXI_LEN  = 8'd7;
  localparam logic [2:0] AXI_SIZE = 3'b010;
  localparam logic [1:0] AXI_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DATA  = 3'd2,
    ST_TAG   = 3'd3,
    ST_DONE  = 3'd4,
    ST_DRAIN = 3'd5
  } refill_state_t;

  function automatic logic [1:0] way_onehot(input logic way);
    if (way) begin
      way_onehot = 2'b10;
    end else begin
      way_onehot = 2'b01;
    end
  endfunction

  function automatic logic [BEATS-1:0] bank_onehot(input logic [2:0] k);
    bank_onehot = 8'b0000_0001 << k;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bundle of miss-request, AXI read-channel and SRAM-write signals around the refill
// sequencer; master is the sequencer side, slave the environment side.
interface icache_refill_ctrl_if;
  import icache_refill_ctrl_pkg::*;

  logic                   MissReq;
  logic [31:0]            MissAddr;
  logic                   MissWay;
  logic                   CacheStateFluah;

  logic                   ReadMAble;
  logic                   ReadMBrustAble;
  logic [31:0]            ReadMAddr;
  logic [7:0]             ReadMlen;
  logic [2:0]             ReadMsize;
  logic [1:0]             ReadMBurstTy;
  logic                   MemoryBrustAble;
  logic                   MemoryAble;
  logic [31:0]            MemoryDate;

  logic [1:0]             DataWe;
  logic [BEATS-1:0]       DataBankWe;
  logic [INDEXWIDE-1:0]   DataWAddr;
  logic [31:0]            DataWDate;
  logic [1:0]             TagWe;
  logic [INDEXWIDE-1:0]   TagWAddr;
  logic [TAGWIDE:0]       TagWDate;

  logic                   RefillBusy;
  logic                   RefillDone;
  logic [32*BEATS-1:0]    RefillLine;

  modport master (
    input  MissReq, MissAddr, MissWay, CacheStateFluah,
    input  MemoryBrustAble, MemoryAble, MemoryDate,
    output ReadMAble, ReadMBrustAble, ReadMAddr, ReadMlen, ReadMsize, ReadMBurstTy,
    output DataWe, DataBankWe, DataWAddr, DataWDate,
    output TagWe, TagWAddr, TagWDate,
    output RefillBusy, RefillDone, RefillLine
  );

  modport slave (
    output MissReq, MissAddr, MissWay, CacheStateFluah,
    output MemoryBrustAble, MemoryAble, MemoryDate,
    input  ReadMAble, ReadMBrustAble, ReadMAddr, ReadMlen, ReadMsize, ReadMBurstTy,
    input  DataWe, DataBankWe, DataWAddr, DataWDate,
    input  TagWe, TagWAddr, TagWDate,
    input  RefillBusy, RefillDone, RefillLine
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// ICache miss-refill sequencer: one 8-beat INCR burst per miss, per-beat data SRAM
// writes into the victim way, then tag write and a one-cycle line handoff.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
(
  input  logic                Clk,
  input  logic                Rest,
  icache_refill_ctrl_if.master bus
);

  refill_state_t            state_r;
  refill_state_t            state_s;

  logic [31:OFFSET]         miss_line_r;
  logic                     way_r;
  logic [2:0]               beat_cnt_r;
  logic [BEATS-1:0][31:0]   line_r;

  logic                     start_s;
  logic                     beat_take_s;
  logic                     beat_last_s;
  logic                     beat_write_s;
  logic                     done_s;
  logic [31:OFFSET]         line_addr_s;

  logic                     read_able_r;
  logic [31:0]              read_addr_r;
  logic                     busy_r;
  logic [1:0]               data_we_r;
  logic [BEATS-1:0]         data_bank_we_r;
  logic [INDEXWIDE-1:0]     data_waddr_r;
  logic [31:0]              data_wdata_r;
  logic [1:0]               tag_we_r;
  logic [INDEXWIDE-1:0]     tag_waddr_r;
  logic [TAGWIDE:0]         tag_wdata_r;

  assign start_s      = (state_r == ST_IDLE) && bus.MissReq;
  assign beat_take_s  = ((state_r == ST_DATA) || (state_r == ST_DRAIN)) && bus.MemoryAble;
  assign beat_last_s  = beat_take_s && (beat_cnt_r == 3'd7);
  // A beat coinciding with a flush is consumed (counted) but never written.
  assign beat_write_s = (state_r == ST_DATA) && bus.MemoryAble && !bus.CacheStateFluah;
  assign done_s       = (state_r == ST_DONE) && !bus.CacheStateFluah;
  assign line_addr_s  = start_s ? bus.MissAddr[31:OFFSET] : miss_line_r;

  // State register
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.MissReq) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Once the bridge accepts, all eight beats will arrive and must be drained.
        if (bus.MemoryBrustAble) begin
          if (bus.CacheStateFluah) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_DATA;
          end
        end else if (bus.CacheStateFluah) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DATA: begin
        if (bus.CacheStateFluah) begin
          if (beat_last_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else if (beat_last_s) begin
          state_s = ST_TAG;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DRAIN: begin
        if (beat_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_TAG:  state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Miss context, beat counter and line buffer
  always_ff @(posedge Clk) begin
    if (Rest) begin
      miss_line_r <= '0;
      way_r       <= 1'b0;
      beat_cnt_r  <= 3'd0;
      line_r      <= '0;
    end else if (start_s) begin
      miss_line_r <= bus.MissAddr[31:OFFSET];
      way_r       <= bus.MissWay;
      beat_cnt_r  <= 3'd0;
      line_r      <= '0;
    end else begin
      if (beat_take_s) begin
        beat_cnt_r <= beat_cnt_r + 3'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      if (beat_write_s) begin
        line_r[beat_cnt_r] <= bus.MemoryDate;
      end else begin
        line_r <= line_r;
      end
    end
  end

  // Read-address channel and busy flag, registered from the next state
  always_ff @(posedge Clk) begin
    if (Rest) begin
      read_able_r <= 1'b0;
      read_addr_r <= 32'h0000_0000;
      busy_r      <= 1'b0;
    end else begin
      read_able_r <= (state_s == ST_REQ);
      busy_r      <= (state_s != ST_IDLE);
      if (state_s == ST_REQ) begin
        read_addr_r <= {line_addr_s, {OFFSET{1'b0}}};
      end else begin
        read_addr_r <= 32'h0000_0000;
      end
    end
  end

  // Per-beat data SRAM write, one cycle after the beat is sampled
  always_ff @(posedge Clk) begin
    if (Rest) begin
      data_we_r      <= 2'b00;
      data_bank_we_r <= '0;
      data_waddr_r   <= '0;
      data_wdata_r   <= 32'h0000_0000;
    end else if (beat_write_s) begin
      data_we_r      <= way_onehot(way_r);
      data_bank_we_r <= bank_onehot(beat_cnt_r);
      data_waddr_r   <= miss_line_r[OFFSET+INDEX-1:OFFSET];
      data_wdata_r   <= bus.MemoryDate;
    end else begin
      data_we_r      <= 2'b00;
      data_bank_we_r <= '0;
      data_waddr_r   <= '0;
      data_wdata_r   <= 32'h0000_0000;
    end
  end

  // Tag write, asserted for exactly the TAG cycle
  always_ff @(posedge Clk) begin
    if (Rest) begin
      tag_we_r    <= 2'b00;
      tag_waddr_r <= '0;
      tag_wdata_r <= '0;
    end else if (state_s == ST_TAG) begin
      tag_we_r    <= way_onehot(way_r);
      tag_waddr_r <= miss_line_r[OFFSET+INDEX-1:OFFSET];
      tag_wdata_r <= {1'b1, miss_line_r[31:OFFSET+INDEX]};
    end else begin
      tag_we_r    <= 2'b00;
      tag_waddr_r <= '0;
      tag_wdata_r <= '0;
    end
  end

  assign bus.ReadMAble      = read_able_r;
  assign bus.ReadMBrustAble = read_able_r;
  assign bus.ReadMAddr      = read_addr_r;
  assign bus.ReadMlen       = AXI_LEN;
  assign bus.ReadMsize      = AXI_SIZE;
  assign bus.ReadMBurstTy   = AXI_INCR;
  assign bus.DataWe         = data_we_r;
  assign bus.DataBankWe     = data_bank_we_r;
  assign bus.DataWAddr      = data_waddr_r;
  assign bus.DataWDate      = data_wdata_r;
  assign bus.TagWe          = tag_we_r;
  assign bus.TagWAddr       = tag_waddr_r;
  assign bus.TagWDate       = tag_wdata_r;
  assign bus.RefillBusy     = busy_r;
  // Done must react to a flush in the same cycle, so it is decoded from state.
  assign bus.RefillDone     = done_s;
  assign bus.RefillLine     = done_s ? line_r : '0;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: a per-cycle vector table for a clean
// refill plus directed sequences for gaps, flushes, held requests and mid-refill reset.
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  logic Clk = 1'b0;
  logic Rest;
  always #5 Clk = ~Clk;

  icache_refill_ctrl_if bus ();

  icache_refill_ctrl dut (
    .Clk  (Clk),
    .Rest (Rest),
    .bus  (bus)
  );

  typedef struct packed {
    logic        req;
    logic        acc;
    logic        vld;
    logic [31:0] d;
    logic        fl;
    logic        e_able;
    logic [31:0] e_raddr;
    logic [1:0]  e_we;
    logic [7:0]  e_bank;
    logic [31:0] e_wdata;
    logic [1:0]  e_twe;
    logic [20:0] e_tdata;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  localparam int NROWS = 13;
  vec_t tbl [NROWS];

  int total = 0;
  int bad   = 0;

  int wr_w0, wr_w1, tag_w0, tag_w1, done_n, able_rise, able_cyc;
  int cyc_no, done_cyc, last_beat_cyc;
  logic able_prev;
  logic [255:0] last_line;
  logic [20:0] last_tdata;
  logic [6:0]  last_waddr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] build_line(input logic [31:0] base);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic drive(input logic req, input logic [31:0] addr, input logic way,
                       input logic acc, input logic vld, input logic [31:0] d, input logic fl);
    bus.MissReq         = req;
    bus.MissAddr        = addr;
    bus.MissWay         = way;
    bus.MemoryBrustAble = acc;
    bus.MemoryAble      = vld;
    bus.MemoryDate      = d;
    bus.CacheStateFluah = fl;
  endtask

  task automatic clear_mon();
    wr_w0 = 0; wr_w1 = 0; tag_w0 = 0; tag_w1 = 0; done_n = 0;
    able_rise = 0; able_cyc = 0; able_prev = 1'b0; cyc_no = 0;
    done_cyc = -1; last_beat_cyc = -1; last_line = '0; last_tdata = '0; last_waddr = '0;
  endtask

  task automatic sample();
    #1;
    if (bus.DataWe[0]) wr_w0++;
    if (bus.DataWe[1]) wr_w1++;
    if (bus.DataWe != 2'b00) last_waddr = bus.DataWAddr;
    if (bus.TagWe[0]) tag_w0++;
    if (bus.TagWe[1]) tag_w1++;
    if (bus.TagWe != 2'b00) last_tdata = bus.TagWDate;
    if (bus.ReadMAble) able_cyc++;
    if (bus.ReadMAble && !able_prev) able_rise++;
    able_prev = bus.ReadMAble;
    if (bus.RefillDone) begin
      done_n++;
      done_cyc  = cyc_no;
      last_line = bus.RefillLine;
    end
  endtask

  task automatic cyc(input logic req, input logic [31:0] addr, input logic way,
                     input logic acc, input logic vld, input logic [31:0] d, input logic fl);
    drive(req, addr, way, acc, vld, d, fl);
    sample();
    @(negedge Clk);
    cyc_no++;
  endtask

  // Full miss with optional idle gaps between beats; req_hold keeps MissReq high throughout.
  task automatic refill(input logic [31:0] addr, input logic way, input logic [31:0] base,
                        input int gap, input logic req_hold);
    cyc(1'b1, addr, way, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(req_hold, addr, way, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) last_beat_cyc = cyc_no;
      cyc(req_hold, addr, way, 1'b0, 1'b1, base + 32'(k), 1'b0);
      if (k < 7) begin
        for (int g = 0; g < gap; g++) cyc(req_hold, addr, way, 1'b0, 1'b0, 32'h0, 1'b0);
      end
    end
    cyc(req_hold, addr, way, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(req_hold, addr, way, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, addr, way, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, addr, way, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [255:0] ref_line;
    ref_line = build_line(32'h0000_00A0);

    // Clean refill, way 0, MissAddr 0x1234_5678: index 0x33, tag 0x12345
    for (int i = 0; i < NROWS; i++) tbl[i] = '0;
    tbl[0].req     = 1'b1;
    tbl[1].acc     = 1'b1;
    tbl[1].e_able  = 1'b1;
    tbl[1].e_raddr = 32'h1234_5660;
    tbl[1].e_busy  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tbl[2+k].vld    = 1'b1;
      tbl[2+k].d      = 32'h0000_00A0 + 32'(k);
      tbl[2+k].e_busy = 1'b1;
      if (k > 0) begin
        tbl[2+k].e_we    = 2'b01;
        tbl[2+k].e_bank  = 8'h01 << (k - 1);
        tbl[2+k].e_wdata = 32'h0000_00A0 + 32'(k - 1);
      end
    end
    tbl[10].e_busy  = 1'b1;
    tbl[10].e_we    = 2'b01;
    tbl[10].e_bank  = 8'h80;
    tbl[10].e_wdata = 32'h0000_00A7;
    tbl[10].e_twe   = 2'b01;
    tbl[10].e_tdata = 21'h11_2345;
    tbl[11].e_busy  = 1'b1;
    tbl[11].e_done  = 1'b1;

    Rest = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge Clk);
    #1;
    check("rst_able",  bus.ReadMAble, 1'b0);
    check("rst_bable", bus.ReadMBrustAble, 1'b0);
    check("rst_raddr", bus.ReadMAddr, 32'h0);
    check("rst_dwe",   {bus.DataWe, bus.DataBankWe, bus.DataWDate}, '0);
    check("rst_twe",   {bus.TagWe, bus.TagWDate}, '0);
    check("rst_busy",  bus.RefillBusy, 1'b0);
    check("rst_done",  bus.RefillDone, 1'b0);
    check("rst_line",  bus.RefillLine, '0);
    check("rst_len",   bus.ReadMlen, 8'd7);
    check("rst_size",  bus.ReadMsize, 3'b010);
    check("rst_burst", bus.ReadMBurstTy, 2'b01);
    Rest = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < NROWS; i++) begin
      drive(tbl[i].req, 32'h1234_5678, 1'b0, tbl[i].acc, tbl[i].vld, tbl[i].d, tbl[i].fl);
      #1;
      check($sformatf("row%0d_able", i), bus.ReadMAble, tbl[i].e_able);
      check($sformatf("row%0d_bable", i), bus.ReadMBrustAble, tbl[i].e_able);
      if (tbl[i].e_able) check($sformatf("row%0d_raddr", i), bus.ReadMAddr, tbl[i].e_raddr);
      check($sformatf("row%0d_dwe", i), bus.DataWe, tbl[i].e_we);
      check($sformatf("row%0d_bank", i), bus.DataBankWe, tbl[i].e_bank);
      if (tbl[i].e_we != 2'b00) begin
        check($sformatf("row%0d_wdata", i), bus.DataWDate, tbl[i].e_wdata);
        check($sformatf("row%0d_waddr", i), bus.DataWAddr, 7'h33);
      end
      check($sformatf("row%0d_twe", i), bus.TagWe, tbl[i].e_twe);
      if (tbl[i].e_twe != 2'b00) begin
        check($sformatf("row%0d_tdata", i), bus.TagWDate, tbl[i].e_tdata);
        check($sformatf("row%0d_taddr", i), bus.TagWAddr, 7'h33);
      end
      check($sformatf("row%0d_busy", i), bus.RefillBusy, tbl[i].e_busy);
      check($sformatf("row%0d_done", i), bus.RefillDone, tbl[i].e_done);
      if (tbl[i].e_done) check($sformatf("row%0d_line", i), bus.RefillLine, ref_line);
      @(negedge Clk);
    end

    // Way 1 with 2-cycle gaps: index 0x7F, tag 0xABCDE
    clear_mon();
    refill(32'hABCD_EFE4, 1'b1, 32'h0000_00B0, 2, 1'b0);
    check("gap_wr_w1",   wr_w1, 8);
    check("gap_wr_w0",   wr_w0, 0);
    check("gap_tag_w1",  tag_w1, 1);
    check("gap_tag_w0",  tag_w0, 0);
    check("gap_done_n",  done_n, 1);
    check("gap_latency", done_cyc - last_beat_cyc, 2);
    check("gap_line",    last_line, build_line(32'h0000_00B0));
    check("gap_tdata",   last_tdata, {1'b1, 20'hABCDE});
    check("gap_waddr",   last_waddr, 7'h7F);

    // Flush in REQ before the bridge accepts
    clear_mon();
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("freq_busy", bus.RefillBusy, 1'b0);
    check("freq_able", bus.ReadMAble, 1'b0);
    @(negedge Clk);
    for (int c = 0; c < 4; c++) cyc(1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h55, 1'b0);
    check("freq_able_cyc", able_cyc, 1);
    check("freq_writes",   wr_w0 + wr_w1 + tag_w0 + tag_w1, 0);
    check("freq_done",     done_n, 0);

    // Flush arriving with beat 4: only beats 0..3 are written
    clear_mon();
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 8; k++)
      cyc(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'hC0 + 32'(k), (k == 4) ? 1'b1 : 1'b0);
    drive(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("fdat_busy", bus.RefillBusy, 1'b0);
    @(negedge Clk);
    for (int c = 0; c < 3; c++) cyc(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("fdat_wr",   wr_w0 + wr_w1, 4);
    check("fdat_tag",  tag_w0 + tag_w1, 0);
    check("fdat_done", done_n, 0);

    // MissReq held high through the whole refill
    clear_mon();
    refill(32'h1234_5678, 1'b0, 32'h0000_00E0, 0, 1'b1);
    check("hold_bursts", able_rise, 1);
    check("hold_done",   done_n, 1);
    check("hold_wr",     wr_w0, 8);

    // Reset in DATA after beat 5, then a normal miss
    clear_mon();
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'hF0 + 32'(k), 1'b0);
    Rest = 1'b1;
    cyc(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    Rest = 1'b0;
    drive(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("rstm_outs", {bus.ReadMAble, bus.DataWe, bus.DataBankWe, bus.DataWDate,
                        bus.TagWe, bus.RefillBusy, bus.RefillDone}, '0);
    @(negedge Clk);
    clear_mon();
    refill(32'h0000_0020, 1'b1, 32'h0000_00D0, 0, 1'b0);
    check("rstm_done",    done_n, 1);
    check("rstm_line",    last_line, build_line(32'h0000_00D0));
    check("rstm_latency", done_cyc - last_beat_cyc, 2);
    check("rstm_wr",      wr_w1, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
